// File: rtl/spu_regfile_dual_wb.sv
// Dual-issue SPU register file shared by the even and odd pipes.
// Clears itself after reset, arbitrates same-address writes and bypasses writes to reads.
module spu_regfile_dual_wb #(
    parameter int DATA_W   = 128,
    parameter int ADDR_W   = 7,
    parameter int RD_PORTS = 3,
    parameter bit BYPASS   = 1'b1,
    parameter bit ODD_WINS = 1'b1,
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [RD_PORTS*ADDR_W-1:0]   ep_rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   ep_rd_data,
    input  logic [RD_PORTS*ADDR_W-1:0]   op_rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   op_rd_data,
    input  logic                         ep_wr_en,
    input  logic [ADDR_W-1:0]            ep_wr_addr,
    input  logic [DATA_W-1:0]            ep_wr_data,
    input  logic                         op_wr_en,
    input  logic [ADDR_W-1:0]            op_wr_addr,
    input  logic [DATA_W-1:0]            op_wr_data,
    output logic                         init_busy,
    output logic                         wr_collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_we;
    logic              ready;
    logic              collide;
    logic              ep_we;
    logic              op_we;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_CLEAR: begin
                if (!CLEAR_EN || (&clr_cnt)) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: state_nxt = ST_READY;
        endcase
    end

    always_comb begin
        init_busy = (state == ST_CLEAR);
        ready     = (state == ST_READY);
        clr_we    = (state == ST_CLEAR) && CLEAR_EN;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // The losing pipe of a same-address pair is masked before it reaches the array.
    always_comb begin
        collide = ready && ep_wr_en && op_wr_en && (ep_wr_addr == op_wr_addr);
        ep_we   = ready && ep_wr_en && !(collide && ODD_WINS);
        op_we   = ready && op_wr_en && !(collide && !ODD_WINS);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_collision <= 1'b0;
        end else begin
            wr_collision <= collide;
        end
    end

    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (ep_we) begin
                mem[ep_wr_addr] <= ep_wr_data;
            end
            if (op_we) begin
                mem[op_wr_addr] <= op_wr_data;
            end
        end
    end

    for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
        logic [ADDR_W-1:0] ea;
        logic [ADDR_W-1:0] oa;
        logic [DATA_W-1:0] ep_q;
        logic [DATA_W-1:0] op_q;

        assign ea = ep_rd_addr[i*ADDR_W +: ADDR_W];
        assign oa = op_rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            ep_q = mem[ea];
            if (BYPASS && ep_we && (ep_wr_addr == ea)) begin
                ep_q = ep_wr_data;
            end
            if (BYPASS && op_we && (op_wr_addr == ea)) begin
                ep_q = op_wr_data;
            end
            if (!ready) begin
                ep_q = '0;
            end
        end

        always_comb begin
            op_q = mem[oa];
            if (BYPASS && ep_we && (ep_wr_addr == oa)) begin
                op_q = ep_wr_data;
            end
            if (BYPASS && op_we && (op_wr_addr == oa)) begin
                op_q = op_wr_data;
            end
            if (!ready) begin
                op_q = '0;
            end
        end

        assign ep_rd_data[i*DATA_W +: DATA_W] = ep_q;
        assign op_rd_data[i*DATA_W +: DATA_W] = op_q;
    end

endmodule
